conv3x3_core: RTL and testbench

CONV3X3_CORE -- requirements
Module: conv3x3_core

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv3x3_core_if.sv | 51 +++++
 rtl/conv_norm_clamp.sv | 39 +++
 rtl/conv3x3_core.sv | 176 +++++++++++++++++
 tb/tb_conv3x3_core.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg -- shared definitions for the 3x3 convolution core.
//   PIX_W / COEF_W / PROD_W / ACC_W : datapath widths
//   N_TAPS, ADDR_W, SHIFT_W         : kernel size and control field widths
//   state_t                         : frame sequencer states
//   IDENT_KERNEL                    : power-on kernel (centre tap = 1)
//   kernel_tap()                    : extract one tap from a packed kernel
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int PIX_W   = 8;
    localparam int COEF_W  = 8;
    localparam int PROD_W  = 17;
    localparam int ACC_W   = 21;
    localparam int N_TAPS  = 9;
    localparam int ADDR_W  = 4;
    localparam int SHIFT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Packed kernel: tap i lives at bits [i*COEF_W +: COEF_W]; tap 4 is the centre.
    localparam logic [N_TAPS*COEF_W-1:0] IDENT_KERNEL =
        {{4{8'h00}}, 8'h01, {4{8'h00}}};

    function automatic logic signed [COEF_W-1:0] kernel_tap(
        input logic [N_TAPS*COEF_W-1:0] kernel,
        input int                       idx
    );
        return kernel[idx*COEF_W +: COEF_W];
    endfunction

endpackage

// File: rtl/conv3x3_core_if.sv
// ---------------------------------------------------------------------------
// conv3x3_core_if -- bundle of the convolution core's control/data signals.
//   start            frame start pulse
//   rd, pixelr1..9   window valid + 3x3 window (row-major, 1 = top-left)
//   coef_we/addr/data coefficient write port (signed taps, index 0..8)
//   shift            normalisation right-shift amount
//   pixelw, wr       filtered pixel + valid
//   busy, frame_done sequencer status
// modport master : the side driving windows/coefficients
// modport slave  : the convolution core
// ---------------------------------------------------------------------------
interface conv3x3_core_if;
    import conv_pkg::*;

    logic               start;
    logic               rd;
    logic [PIX_W-1:0]   pixelr1;
    logic [PIX_W-1:0]   pixelr2;
    logic [PIX_W-1:0]   pixelr3;
    logic [PIX_W-1:0]   pixelr4;
    logic [PIX_W-1:0]   pixelr5;
    logic [PIX_W-1:0]   pixelr6;
    logic [PIX_W-1:0]   pixelr7;
    logic [PIX_W-1:0]   pixelr8;
    logic [PIX_W-1:0]   pixelr9;
    logic               coef_we;
    logic [ADDR_W-1:0]  coef_addr;
    logic [COEF_W-1:0]  coef_data;
    logic [SHIFT_W-1:0] shift;
    logic [PIX_W-1:0]   pixelw;
    logic               wr;
    logic               busy;
    logic               frame_done;

    modport master (
        output start, rd,
        output pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
        output pixelr6, pixelr7, pixelr8, pixelr9,
        output coef_we, coef_addr, coef_data, shift,
        input  pixelw, wr, busy, frame_done
    );

    modport slave (
        input  start, rd,
        input  pixelr1, pixelr2, pixelr3, pixelr4, pixelr5,
        input  pixelr6, pixelr7, pixelr8, pixelr9,
        input  coef_we, coef_addr, coef_data, shift,
        output pixelw, wr, busy, frame_done
    );

endinterface

// File: rtl/conv_norm_clamp.sv
// ---------------------------------------------------------------------------
// conv_norm_clamp -- output normalisation (combinational).
//   sum   : signed accumulator value
//   shift : arithmetic right-shift amount (floor division by 2^shift)
//   pix   : result clamped to 0..255
// Optional macro CONV_ABS_EN: negative shifted values are replaced by their
// magnitude before clamping (edge-detect mode); otherwise they clamp to 0.
// ---------------------------------------------------------------------------
module conv_norm_clamp
    import conv_pkg::*;
(
    input  logic signed [ACC_W-1:0]   sum,
    input  logic        [SHIFT_W-1:0] shift,
    output logic        [PIX_W-1:0]   pix
);

    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] mag;

    always_comb begin
        shifted = sum >>> shift;
`ifdef CONV_ABS_EN
        // Largest magnitude is well inside ACC_W, so negation cannot overflow.
        mag = shifted[ACC_W-1] ? -shifted : shifted;
`else
        mag = shifted;
`endif
        if (mag[ACC_W-1]) begin
            pix = '0;
        end else if (mag > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = mag[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_core.sv
// ---------------------------------------------------------------------------
// conv3x3_core -- 3-stage pipelined 3x3 convolution with frame sequencer.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : conv3x3_core_if.slave (windows, coefficient port, results, status)
// Parameters IMG_W / IMG_H set the number of windows per frame.
// Pipeline: stage 1 products, stage 2 sum, stage 3 shift/clamp -> pixelw.
// A result appears on wr exactly 3 cycles after its window is accepted.
// Optional macro CONV_ABS_EN (in conv_norm_clamp): magnitude instead of
// clamp-to-zero for negative results.
// ---------------------------------------------------------------------------
module conv3x3_core
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    conv3x3_core_if.slave   bus
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIX - 1);

    state_t                    state_reg;
    state_t                    state_next;
    logic [CNT_W-1:0]          cnt_reg;
    logic signed [COEF_W-1:0]  coef_reg [N_TAPS];
    logic [N_TAPS-1:0]         coef_hit;
    logic [PIX_W-1:0]          win [N_TAPS];
    logic signed [PROD_W-1:0]  prod_next [N_TAPS];
    logic signed [PROD_W-1:0]  prod_reg [N_TAPS];
    logic signed [ACC_W-1:0]   sum_next;
    logic signed [ACC_W-1:0]   sum_reg;
    logic [SHIFT_W-1:0]        shift1_reg;
    logic [SHIFT_W-1:0]        shift2_reg;
    logic                      v1_reg;
    logic                      v2_reg;
    logic                      wr_reg;
    logic [PIX_W-1:0]          pixelw_reg;
    logic [PIX_W-1:0]          norm_pix;
    logic                      accept;
    logic                      last_accept;
    logic                      busy_next;
    logic                      done_next;

    assign win[0] = bus.pixelr1;
    assign win[1] = bus.pixelr2;
    assign win[2] = bus.pixelr3;
    assign win[3] = bus.pixelr4;
    assign win[4] = bus.pixelr5;
    assign win[5] = bus.pixelr6;
    assign win[6] = bus.pixelr7;
    assign win[7] = bus.pixelr8;
    assign win[8] = bus.pixelr9;

    assign accept      = (state_reg == RUN) && bus.rd;
    assign last_accept = accept && (cnt_reg == LAST_CNT);

    // Per-tap write decode and product; addresses 9..15 match no tap.
    // The pixel is zero-extended so it multiplies as a positive signed value.
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
            assign coef_hit[gi]  = (state_reg == IDLE) && bus.coef_we &&
                                   (bus.coef_addr == ADDR_W'(gi));
            assign prod_next[gi] = PROD_W'($signed({1'b0, win[gi]})) *
                                   PROD_W'(coef_reg[gi]);
        end
    endgenerate

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                busy_next = 1'b1;
                if (last_accept) state_next = FLUSH;
            end
            FLUSH: begin
                busy_next = 1'b1;
                // Once stages 1 and 2 are empty the final result is in wr_reg,
                // so DONE lands on the cycle right after the last wr.
                if (!v1_reg && !v2_reg) state_next = DONE;
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (state_reg == DONE) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // ---------------- coefficients ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TAPS; i++) begin
            if (!rst_n) begin
                coef_reg[i] <= kernel_tap(IDENT_KERNEL, i);
            end else if (coef_hit[i]) begin
                coef_reg[i] <= bus.coef_data;
            end
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            sum_next = sum_next + ACC_W'(prod_reg[i]);
        end
    end

    // Valid bits and output registers are reset; payload registers are not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            pixelw_reg <= '0;
        end else begin
            v1_reg     <= accept;
            v2_reg     <= v1_reg;
            wr_reg     <= v2_reg;
            pixelw_reg <= v2_reg ? norm_pix : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_TAPS; i++) begin
                prod_reg[i] <= prod_next[i];
            end
            shift1_reg <= bus.shift;
        end
        if (v1_reg) begin
            sum_reg    <= sum_next;
            shift2_reg <= shift1_reg;
        end
    end

    conv_norm_clamp u_norm (
        .sum   (sum_reg),
        .shift (shift2_reg),
        .pix   (norm_pix)
    );

    assign bus.pixelw     = pixelw_reg;
    assign bus.wr         = wr_reg;
    assign bus.busy       = busy_next;
    assign bus.frame_done = done_next;

endmodule

// File: tb/tb_conv3x3_core.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_core -- self-checking bench for conv3x3_core (IMG_W = IMG_H = 4).
// Table of kernel/window vectors with known results, a queue of expected
// results with their due cycle, and hand-written reset/ignore sequences.
// Honours CONV_ABS_EN for the expected values of negative results.
// ---------------------------------------------------------------------------
module tb_conv3x3_core;

`ifdef CONV_ABS_EN
    localparam bit ABS_MODE = 1'b1;
`else
    localparam bit ABS_MODE = 1'b0;
`endif

    localparam int FRAME_N = 16;

    typedef struct packed {
        logic [71:0] coefs;
        logic [71:0] pix;
        logic [3:0]  sh;
        int          expv;
    } vec_t;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   frame_wr = 0;
    int   last_wr_cyc = -1;
    exp_t exp_q[$];
    logic [7:0] model_coef [9];
    vec_t tbl [7];

    conv3x3_core_if bus ();

    conv3x3_core #(.IMG_W(4), .IMG_H(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Output monitor: every wr pops one expectation and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wr === 1'b1) begin
            frame_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixelw", int'(bus.pixelw), e.val);
                check("wr_latency", cyc, e.due);
                $display("[TB] result pixelw=%0d expected=%0d cycle=%0d", bus.pixelw, e.val, cyc);
            end
        end else begin
            check("pixelw_idle_zero", int'(bus.pixelw), 0);
        end
    end

    function automatic int model(input logic [71:0] pix, input logic [3:0] sh);
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            s += int'(pix[i*8 +: 8]) * int'($signed(model_coef[i]));
        end
        s = s >>> sh;
        if (ABS_MODE && s < 0) s = -s;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic logic [71:0] rand_pix();
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic clear_ctl();
        bus.start   = 1'b0;
        bus.rd      = 1'b0;
        bus.coef_we = 1'b0;
    endtask

    task automatic set_pix(input logic [71:0] p, input logic [3:0] sh);
        bus.pixelr1 = p[7:0];
        bus.pixelr2 = p[15:8];
        bus.pixelr3 = p[23:16];
        bus.pixelr4 = p[31:24];
        bus.pixelr5 = p[39:32];
        bus.pixelr6 = p[47:40];
        bus.pixelr7 = p[55:48];
        bus.pixelr8 = p[63:56];
        bus.pixelr9 = p[71:64];
        bus.shift   = sh;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        clear_ctl();
        set_pix(rand_pix(), 4'($urandom_range(0, 15)));
    endtask

    task automatic put_window(input logic [71:0] p, input logic [3:0] sh,
                              input int expv, input bit push);
        @(negedge clk);
        clear_ctl();
        set_pix(p, sh);
        bus.rd = 1'b1;
        if (push) exp_q.push_back('{val: expv, due: cyc + 3});
    endtask

    task automatic write_coef(input int addr, input logic [7:0] data, input bit st);
        @(negedge clk);
        clear_ctl();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_data = data;
        bus.start     = st;
        if (addr < 9) model_coef[addr] = data;
    endtask

    // Loads a full kernel in IDLE; the last write carries the start pulse.
    task automatic load_coefs(input logic [71:0] k);
        for (int i = 0; i < 9; i++) write_coef(i, k[i*8 +: 8], i == 8);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 9; i++) model_coef[i] = (i == 4) ? 8'h01 : 8'h00;
    endtask

    // One full frame of 16 windows with random rd gaps, then a 17th rd that
    // must be ignored, then the frame_done checks.
    task automatic run_frame(input logic [71:0] pix0, input logic [3:0] sh0,
                             input int exp0, input bit do_start, input bit we_in_run);
        logic [71:0] p;
        logic [3:0]  s;
        bit          got;
        if (do_start) begin
            @(negedge clk);
            clear_ctl();
            bus.start = 1'b1;
        end
        idle_cycle();
        check("busy_in_run", int'(bus.busy), 1);
        frame_wr = 0;
        if (we_in_run) begin
            @(negedge clk);
            clear_ctl();
            bus.coef_we   = 1'b1;
            bus.coef_addr = 4'd4;
            bus.coef_data = 8'h00;
        end
        for (int w = 0; w < FRAME_N; w++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            if (w == 0) begin
                put_window(pix0, sh0, exp0, 1'b1);
            end else begin
                p = rand_pix();
                s = 4'($urandom_range(0, 15));
                put_window(p, s, model(p, s), 1'b1);
            end
        end
        put_window(rand_pix(), 4'd0, 0, 1'b0);
        idle_cycle();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.frame_done === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check("frame_done_seen", int'(got), 1);
        if (got) begin
            check("frame_done_after_last_wr", cyc, last_wr_cyc + 1);
            check("frame_wr_count", frame_wr, FRAME_N);
            check("queue_drained", exp_q.size(), 0);
            $display("[TB] frame done cycle=%0d wr_count=%0d", cyc, frame_wr);
            @(negedge clk);
            check("frame_done_one_cycle", int'(bus.frame_done), 0);
            check("busy_after_frame", int'(bus.busy), 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{coefs: {9{8'h01}}, pix: {9{8'd200}}, sh: 4'd3, expv: 225};
        tbl[1] = '{coefs: {9{8'h01}}, pix: {9{8'd255}}, sh: 4'd0, expv: 255};
        tbl[2] = '{coefs: {32'h0, 8'hFF, 32'h0}, pix: {9{8'd50}}, sh: 4'd0,
                   expv: ABS_MODE ? 50 : 0};
        tbl[3] = '{coefs: {{4{8'hFF}}, 8'h08, {4{8'hFF}}},
                   pix: {{4{8'd10}}, 8'd100, {4{8'd10}}}, sh: 4'd2, expv: 180};
        tbl[4] = '{coefs: {32'h0, 8'hFF, 32'h0},
                   pix: {{4{8'd9}}, 8'd5, {4{8'd9}}}, sh: 4'd1, expv: ABS_MODE ? 3 : 0};
        tbl[5] = '{coefs: {9{8'h80}}, pix: {9{8'd255}}, sh: 4'd15, expv: ABS_MODE ? 9 : 0};
        tbl[6] = '{coefs: {9{8'h7F}}, pix: {9{8'd255}}, sh: 4'd15, expv: 8};

        clear_ctl();
        bus.coef_addr = '0;
        bus.coef_data = '0;
        set_pix('0, 4'd0);
        reset_model();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr", int'(bus.wr), 0);
        check("reset_pixelw", int'(bus.pixelw), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        rst_n = 1'b1;
        idle_cycle();

        // Reset kernel is identity; a coefficient write during RUN is ignored.
        run_frame({9{8'd100}}, 4'd0, 100, 1'b1, 1'b1);

        // Table-driven kernels
        for (int t = 0; t < 7; t++) begin
            $display("[TB] vector %0d shift=%0d expected=%0d", t, tbl[t].sh, tbl[t].expv);
            load_coefs(tbl[t].coefs);
            run_frame(tbl[t].pix, tbl[t].sh, tbl[t].expv, 1'b0, 1'b0);
        end

        // Mid-frame reset after 5 windows with a box kernel loaded.
        load_coefs({9{8'h01}});
        idle_cycle();
        for (int w = 0; w < 5; w++) begin
            logic [71:0] p;
            p = rand_pix();
            put_window(p, 4'd3, model(p, 4'd3), 1'b1);
        end
        @(negedge clk);
        clear_ctl();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wr_after_reset", int'(bus.wr), 0);
            check("busy_after_reset", int'(bus.busy), 0);
        end
        $display("[TB] mid-frame reset sequence complete");

        // Next frame must use the identity kernel again.
        run_frame({{4{8'd3}}, 8'd77, {4{8'd200}}}, 4'd0, 77, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
